// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: default depth, the NOP
// presented to decode when the queue is empty, and the stored entry layout.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH_DEFAULT = 4;
    localparam int unsigned FQ_IW            = 32;
    localparam int unsigned FQ_AW            = 32;
    localparam int unsigned FQ_ADEL_W        = 1;

    // sll $0,$0,0 -- decode treats an all-zero word as a bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Entry layout in storage: {adel, pc, instr}
    function automatic int unsigned fq_entry_w(input int unsigned aw, input int unsigned iw);
        return aw + iw + FQ_ADEL_W;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Register array for fetch-queue entries: one synchronous write port and one
// asynchronous read port. Contents are never reset; occupancy lives in the parent.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
    parameter int unsigned W     = fq_entry_w(FQ_AW, FQ_IW)
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// First-word-fall-through queue between fetch and decode. Holds PC, instruction
// and fetch address-error flag; flush drops everything, empty presents a NOP.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
    parameter int unsigned IW    = FQ_IW,
    parameter int unsigned AW    = FQ_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [AW-1:0]          push_pc,
    input  logic [IW-1:0]          push_instr,
    input  logic                   push_adel,
    output logic                   pop_valid,
    input  logic                   pop_ready,
    output logic [AW-1:0]          pop_pc,
    output logic [IW-1:0]          pop_instr,
    output logic                   pop_adel,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = fq_entry_w(AW, IW);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    // rst gates push_ready directly so it is low for the whole reset pulse
    assign push_ready = ~full & ~flush & ~rst;
    assign pop_valid  = ~empty & ~flush;

    assign w_push = push_valid & push_ready;
    assign w_pop  = pop_valid & pop_ready;

    assign w_wdata = {push_adel, push_pc, push_instr};

    fq_storage #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // Head fields are masked when empty so stale storage never reaches decode
    assign pop_instr = empty ? IW'(NOP_INSTR) : w_rdata[IW-1:0];
    assign pop_pc    = empty ? '0 : w_rdata[IW +: AW];
    assign pop_adel  = ~empty & w_rdata[EW-1];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): ordering, full, steady-state wrap,
// flush, asynchronous reset and address-error passthrough.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 32;
    localparam int unsigned AW    = 32;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          push_valid;
    logic          push_ready;
    logic [AW-1:0] push_pc;
    logic [IW-1:0] push_instr;
    logic          push_adel;
    logic          pop_valid;
    logic          pop_ready;
    logic [AW-1:0] pop_pc;
    logic [IW-1:0] pop_instr;
    logic          pop_adel;
    logic [2:0]    count;
    logic          full;
    logic          empty;

    int unsigned n_cmp;
    int unsigned n_err;
    logic [31:0] expq[$];

    fetch_queue #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_pc    (push_pc),
        .push_instr (push_instr),
        .push_adel  (push_adel),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_pc     (pop_pc),
        .pop_instr  (pop_instr),
        .pop_adel   (pop_adel),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic adel);
        push_valid = 1'b1;
        push_pc    = pc;
        push_instr = ins(pc);
        push_adel  = adel;
        tick();
        push_valid = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        push_pc = '0; push_instr = '0; push_adel = 1'b0;
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_push_ready", 64'(push_ready), 64'd0);
        check("rst_pop_valid", 64'(pop_valid), 64'd0);
        check("rst_pop_instr", 64'(pop_instr), 64'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("post_rst_push_ready", 64'(push_ready), 64'd1);

        // ordering: no bypass while empty
        push_valid = 1'b1; push_pc = 32'hBFC0_0000; push_instr = ins(32'hBFC0_0000);
        #1;
        check("no_bypass_pop_valid", 64'(pop_valid), 64'd0);
        check("no_bypass_pop_pc", 64'(pop_pc), 64'd0);
        tick();
        push_valid = 1'b0;
        #1;
        check("first_push_count", 64'(count), 64'd1);
        check("first_push_pop_valid", 64'(pop_valid), 64'd1);
        push_one(32'hBFC0_0004, 1'b0);
        push_one(32'hBFC0_0008, 1'b0);
        check("order_count3", 64'(count), 64'd3);
        pop_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("order_pc", 64'(pop_pc), 64'(32'hBFC0_0000 + 32'(4 * k)));
            check("order_instr", 64'(pop_instr), 64'(ins(32'hBFC0_0000 + 32'(4 * k))));
            check("order_count", 64'(count), 64'(3 - k));
            tick();
        end
        pop_ready = 1'b0;
        #1;
        check("order_count0", 64'(count), 64'd0);
        check("order_empty", 64'(empty), 64'd1);
        check("order_pop_valid", 64'(pop_valid), 64'd0);
        check("order_pop_pc_zero", 64'(pop_pc), 64'd0);

        // full
        for (int k = 0; k < 4; k++) push_one(32'h100 + 32'(4 * k), 1'b0);
        check("full_flag", 64'(full), 64'd1);
        check("full_push_ready", 64'(push_ready), 64'd0);
        check("full_count", 64'(count), 64'd4);

        // full with simultaneous pop: only the pop fires
        push_valid = 1'b1; push_pc = 32'h200; push_instr = ins(32'h200); pop_ready = 1'b1;
        #1;
        check("fullpop_head", 64'(pop_pc), 64'h100);
        tick();
        push_valid = 1'b0; pop_ready = 1'b0;
        #1;
        check("fullpop_count", 64'(count), 64'd3);
        check("fullpop_full", 64'(full), 64'd0);
        check("fullpop_head2", 64'(pop_pc), 64'h104);

        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        #1;
        check("steady_start_count", 64'(count), 64'd2);
        expq.push_back(32'h108);
        expq.push_back(32'h10C);

        // steady state across pointer wrap
        push_valid = 1'b1; pop_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_pc = 32'h300 + 32'(4 * i);
            push_instr = ins(push_pc);
            #1;
            check("steady_pc", 64'(pop_pc), 64'(expq[0]));
            tick();
            expq.push_back(32'h300 + 32'(4 * i));
            void'(expq.pop_front());
            check("steady_count", 64'(count), 64'd2);
        end
        push_valid = 1'b0; pop_ready = 1'b0;
        #1;
        push_one(32'h400, 1'b0);
        check("preflush_count", 64'(count), 64'd3);
        check("preflush_head", 64'(pop_pc), 64'(expq[0]));

        // flush wins over push and pop
        flush = 1'b1; push_valid = 1'b1; push_pc = 32'h500; push_instr = ins(32'h500); pop_ready = 1'b1;
        #1;
        check("flush_push_ready", 64'(push_ready), 64'd0);
        check("flush_pop_valid", 64'(pop_valid), 64'd0);
        tick();
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        expq.delete();
        #1;
        check("flush_count", 64'(count), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_pop_instr", 64'(pop_instr), 64'd0);
        push_one(32'h600, 1'b0);
        check("postflush_count", 64'(count), 64'd1);
        check("postflush_head", 64'(pop_pc), 64'h600);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;

        // asynchronous reset between edges
        push_one(32'h700, 1'b0);
        push_one(32'h704, 1'b0);
        check("prerst_count", 64'(count), 64'd2);
        #1;
        rst = 1'b1;
        #1;
        check("arst_pop_valid", 64'(pop_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_push_ready", 64'(push_ready), 64'd0);
        check("arst_pop_pc", 64'(pop_pc), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("arst_release_ready", 64'(push_ready), 64'd1);
        check("arst_release_empty", 64'(empty), 64'd1);

        // address-error flag travels with its entry
        push_one(32'hBFC0_0002, 1'b1);
        push_one(32'hBFC0_0004, 1'b0);
        check("adel_pc", 64'(pop_pc), 64'hBFC0_0002);
        check("adel_set", 64'(pop_adel), 64'd1);
        pop_ready = 1'b1;
        tick();
        check("adel_next_pc", 64'(pop_pc), 64'hBFC0_0004);
        check("adel_clear", 64'(pop_adel), 64'd0);
        tick();
        pop_ready = 1'b0;
        #1;
        check("adel_empty", 64'(empty), 64'd1);
        check("adel_empty_flag", 64'(pop_adel), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the number of entries; legal values are powers of two, 2..16.
REQ-002 Parameter IW, default 32, SHALL be the instruction width.
REQ-003 Parameter AW, default 32, SHALL be the PC width.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port flush, input, 1: discard all entries (branch redirect, exception or eret).
REQ-007 Port push_valid, input, 1: the fetch stage offers an entry.
REQ-008 Port push_ready, output, 1: the queue accepts the offered entry this cycle.
REQ-009 Port push_pc, input, AW: PC of the fetched instruction.
REQ-010 Port push_instr, input, IW: fetched instruction word.
REQ-011 Port push_adel, input, 1: fetch address-error flag.
REQ-012 Port pop_valid, output, 1: a head entry is available to decode.
REQ-013 Port pop_ready, input, 1: decode consumes the head entry (the IF_ID write enable).
REQ-014 Ports pop_pc (AW), pop_instr (IW) and pop_adel (1), outputs: head entry fields.
REQ-015 Port count, output, $clog2(DEPTH)+1: number of occupied entries.
REQ-016 Ports full and empty, outputs, 1 each: count==DEPTH and count==0 respectively.

Function
REQ-017 A push SHALL fire when push_valid & push_ready; a pop SHALL fire when pop_valid & pop_ready.
REQ-018 push_ready SHALL be ~full & ~flush, with no combinational dependence on pop_ready.
REQ-019 pop_valid SHALL be ~empty & ~flush.
REQ-020 The queue SHALL be first-word-fall-through: the head entry appears on the pop_* ports combinationally from storage.
REQ-021 A pushed entry SHALL become poppable on the cycle after its push, never in the same cycle (no empty bypass).
REQ-022 While empty, pop_pc, pop_instr and pop_adel SHALL all be 0, so decode sees a NOP (sll $0,$0,0).
REQ-023 On a push-only cycle, count SHALL increment by 1.
REQ-024 On a pop-only cycle, count SHALL decrement by 1.
REQ-025 When a push and a pop fire together, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 When full, a push SHALL NOT fire even if a pop fires in the same cycle.
REQ-028 A pop while empty SHALL NOT occur: pop_valid is 0, so pointers and count hold.
REQ-029 flush SHALL take priority over any push or pop in the same cycle.
REQ-030 On the edge after flush, count SHALL be 0 and both pointers SHALL be 0.
REQ-031 Entries are held only in storage; the flush cycle's push is dropped, and push_ready is 0 during flush.
REQ-032 push_adel SHALL be stored and returned with its entry unchanged.
REQ-033 The queue SHALL NOT raise or suppress exceptions itself.
REQ-034 Storage contents SHALL NOT affect outputs unless the entry is occupied.

Reset
REQ-035 Asserting rst SHALL immediately clear count and both pointers to 0, so empty=1, full=0 and push_ready=0 while rst is high.
REQ-036 Asserting rst SHALL force pop_valid=0 and pop_pc, pop_instr and pop_adel to 0.
REQ-037 Storage array SHALL NOT require reset.
REQ-038 Reset asserted mid-transfer SHALL discard all entries; no partial entry survives.
REQ-039 After rst deasserts, push_ready SHALL be 1 in the first cycle without flush.

Structure
REQ-040 The shared header SHALL hold the FQ_DEPTH_DEFAULT constant.
REQ-041 The shared header SHALL hold the NOP_INSTR constant (32'h0000_0000).
REQ-042 The shared header SHALL hold the entry field widths.
REQ-043 One sub-module, fq_storage, SHALL hold the DEPTH x (AW+IW+1) register array.
REQ-044 fq_storage SHALL have one write port and one asynchronous read port.
REQ-045 Control (pointers, count, flush and handshake) SHALL reside in fetch_queue.

Verification
REQ-046 Ordering: reset; push PCs 0xBFC00000, 0xBFC00004 and 0xBFC00008 with pop_ready=0; then pop_ready=1 -> pops in the same order; count goes 3,2,1,0; empty=1 after.
REQ-047 Full: push 4 entries (DEPTH=4) -> full=1 and push_ready=0.
REQ-048 Full with pop: in the full state, push_valid=1 and pop_ready=1 for one cycle -> one pop, no push, count=3.
REQ-049 Steady-state: push and pop every cycle for 20 cycles starting at count=2 -> count stays 2 and PCs emerge in order across pointer wrap.
REQ-050 Flush: with count=3, flush plus push_valid plus pop_ready -> next cycle count=0, the pushed entry is absent, and pop_instr=0.
REQ-051 Reset mid-run: rst asserted asynchronously between edges with count=2 -> pop_valid=0 and count=0 immediately, before the next clock edge.
REQ-052 AdEL passthrough: push PC 0xBFC00002 with adel=1 -> popped with pop_adel=1; the following entry has pop_adel=0.
